// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types and constants for the instruction fetch front end.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    // Fetch controller states: BOOT idles one cycle out of reset, RUN fetches
    // normally, FLUSH fetches while wrong-path responses are still draining.
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } FetchState_t;

    localparam int                 INSTR_W   = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

endpackage
`default_nettype wire

// File: rtl/instr_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fifo
//  Description : Small synchronous FIFO with flush and occupancy output.
//                Head entry is read combinationally from storage.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_push_data,
    input  logic                   i_pop,
    input  logic                   i_flush,
    output logic [WIDTH-1:0]       o_head_data,
    output logic                   o_head_valid,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_pop;
    logic               w_push;

    // Pops on an empty FIFO are ignored; a push is accepted when there is room
    // or when the head leaves in the same cycle.
    assign w_pop  = i_pop & (r_count != '0);
    assign w_push = i_push & ((r_count != c_cnt_w'(DEPTH)) | w_pop);

    // Pointer and occupancy bookkeeping; flush empties the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            r_count <= r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
        end
    end

    // Storage write; contents need no reset since validity is tracked by count.
    always_ff @(posedge clk) begin
        if (w_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    assign o_head_data  = r_mem[r_rd_ptr];
    assign o_head_valid = (r_count != '0);
    assign o_count      = r_count;

endmodule
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fetch_unit
//  Description : PC register and instruction fetch front end. Issues in-order
//                requests to instruction memory under a credit limit, drops
//                wrong-path responses after a redirect and buffers fetched
//                instructions for decode.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_unit
    import fetch_pkg::*;
#(
    parameter int              PC_W       = 9,
    parameter logic [PC_W-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               PcSel,
    input  logic [31:0]        NextPC,
    input  logic               Stall,
    output logic               ImemReqValid,
    output logic [PC_W-1:0]    ImemReqAddr,
    input  logic               ImemReqReady,
    input  logic               ImemRspValid,
    input  logic [INSTR_W-1:0] ImemRspData,
    output logic               InstrValid,
    output logic [INSTR_W-1:0] Instr,
    output logic [PC_W-1:0]    InstrPC,
    input  logic               InstrReady,
    output logic               Misaligned
);

    localparam int c_cnt_w   = $clog2(FIFO_DEPTH) + 1;
    localparam int c_sum_w   = c_cnt_w + 1;
    localparam int c_entry_w = INSTR_W + PC_W;

    FetchState_t          r_state;
    FetchState_t          w_state_next;
    logic [PC_W-1:0]      r_pc;
    logic [c_cnt_w-1:0]   r_outstanding;
    logic [c_cnt_w-1:0]   w_outstanding_next;
    logic [c_cnt_w-1:0]   r_squash;
    logic [c_cnt_w-1:0]   w_squash_next;
    logic                 r_misaligned;
    logic                 w_credit_ok;
    logic                 w_req_fire;
    logic                 w_rsp_keep;
    logic [PC_W-1:0]      w_redirect_pc;
    logic [c_cnt_w-1:0]   w_fifo_count;
    logic [c_entry_w-1:0] w_fifo_head;
    logic                 w_fifo_valid;
    logic [PC_W-1:0]      w_pcq_head;
    logic                 w_pcq_valid;
    logic [c_cnt_w-1:0]   w_pcq_count;
    logic                 w_unused;

    // Upper redirect bits beyond the PC width and PC-queue status are not needed.
    assign w_unused = &{1'b0, NextPC[31:PC_W], w_pcq_valid, w_pcq_count};

    // Every in-flight request, squashed or not, reserves a buffer slot so that
    // responses never need backpressure.
    assign w_credit_ok   = (c_sum_w'(r_outstanding) + c_sum_w'(w_fifo_count))
                           < c_sum_w'(FIFO_DEPTH);
    assign w_req_fire    = ImemReqValid & ImemReqReady;
    assign w_rsp_keep    = ImemRspValid & ~PcSel & (r_squash == '0);
    assign w_redirect_pc = {NextPC[PC_W-1:2], 2'b00};

    // In-flight count and squash count for the next cycle. A redirect squashes
    // everything still in flight except a response landing in the same cycle,
    // which is dropped directly.
    always_comb begin
        w_outstanding_next = r_outstanding + c_cnt_w'(w_req_fire) - c_cnt_w'(ImemRspValid);
        w_squash_next      = r_squash;
        if (PcSel) begin
            w_squash_next = r_outstanding - c_cnt_w'(ImemRspValid);
        end else if (ImemRspValid && (r_squash != '0)) begin
            w_squash_next = r_squash - c_cnt_w'(1);
        end
    end

    // Next-state and request-valid decode.
    always_comb begin
        w_state_next = r_state;
        ImemReqValid = 1'b0;
        case (r_state)
            BOOT: begin
                w_state_next = RUN;
            end
            RUN, FLUSH: begin
                ImemReqValid = ~PcSel & ~Stall & w_credit_ok;
                w_state_next = (w_squash_next != '0) ? FLUSH : RUN;
            end
            default: begin
                w_state_next = BOOT;
            end
        endcase
    end

    // Fetch state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // PC, counters and misalignment pulse; a redirect takes priority over advance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_outstanding <= '0;
            r_squash      <= '0;
            r_misaligned  <= 1'b0;
        end else begin
            r_outstanding <= w_outstanding_next;
            r_squash      <= w_squash_next;
            r_misaligned  <= PcSel & (NextPC[1:0] != 2'b00);
            if (PcSel) begin
                r_pc <= w_redirect_pc;
            end else if (w_req_fire) begin
                r_pc <= r_pc + PC_W'(4);
            end
        end
    end

    // Addresses of live (non-squashed) requests, matched to responses in order.
    instr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PC_W)
    ) u_pc_queue (
        .clk          (clk),
        .rst          (reset),
        .i_push       (w_req_fire),
        .i_push_data  (r_pc),
        .i_pop        (w_rsp_keep),
        .i_flush      (PcSel),
        .o_head_data  (w_pcq_head),
        .o_head_valid (w_pcq_valid),
        .o_count      (w_pcq_count)
    );

    // Instruction buffer feeding decode.
    instr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (c_entry_w)
    ) u_instr_fifo (
        .clk          (clk),
        .rst          (reset),
        .i_push       (w_rsp_keep),
        .i_push_data  ({ImemRspData, w_pcq_head}),
        .i_pop        (InstrValid & InstrReady),
        .i_flush      (PcSel),
        .o_head_data  (w_fifo_head),
        .o_head_valid (w_fifo_valid),
        .o_count      (w_fifo_count)
    );

    assign ImemReqAddr = r_pc;
    assign InstrValid  = w_fifo_valid;
    assign Instr       = w_fifo_valid ? w_fifo_head[c_entry_w-1:PC_W] : '0;
    assign InstrPC     = w_fifo_valid ? w_fifo_head[PC_W-1:0] : '0;
    assign Misaligned  = r_misaligned;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_fetch_unit
//  Description : Directed self-checking bench for pc_fetch_unit with an
//                in-order instruction memory of configurable latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        PcSel = 1'b0;
    logic [31:0] NextPC = '0;
    logic        Stall = 1'b0;
    logic        ImemReqValid;
    logic [8:0]  ImemReqAddr;
    logic        ImemReqReady = 1'b1;
    logic        ImemRspValid = 1'b0;
    logic [31:0] ImemRspData = '0;
    logic        InstrValid;
    logic [31:0] Instr;
    logic [8:0]  InstrPC;
    logic        InstrReady = 1'b1;
    logic        Misaligned;

    pc_fetch_unit #(
        .PC_W       (9),
        .RESET_PC   (9'h000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .PcSel        (PcSel),
        .NextPC       (NextPC),
        .Stall        (Stall),
        .ImemReqValid (ImemReqValid),
        .ImemReqAddr  (ImemReqAddr),
        .ImemReqReady (ImemReqReady),
        .ImemRspValid (ImemRspValid),
        .ImemRspData  (ImemRspData),
        .InstrValid   (InstrValid),
        .Instr        (Instr),
        .InstrPC      (InstrPC),
        .InstrReady   (InstrReady),
        .Misaligned   (Misaligned)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] addr;
        int         due;
    } req_t;

    req_t       q[$];
    int         lat = 1;
    int         cyc_n = 0;
    int         n_fire = 0;
    int         n_tests = 0;
    int         n_fail = 0;
    logic [8:0] exp_pc = '0;
    logic [8:0] last_addr = '0;
    logic [8:0] prev_addr = '0;

    function automatic logic [31:0] mem_data(input logic [8:0] a);
        return 32'hC0DE_0000 | {23'd0, a};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: observe pops and requests, clock, then drive memory response.
    task automatic cyc();
        #1;
        if (InstrValid && InstrReady) begin
            check("pop_pc", 32'(InstrPC), 32'(exp_pc));
            check("pop_instr", Instr, mem_data(exp_pc));
            exp_pc = exp_pc + 9'd4;
        end
        if (PcSel) exp_pc = {NextPC[8:2], 2'b00};
        if (ImemReqValid && ImemReqReady) begin
            q.push_back('{addr: ImemReqAddr, due: cyc_n + lat});
            n_fire++;
            prev_addr = last_addr;
            last_addr = ImemReqAddr;
        end
        @(posedge clk);
        cyc_n++;
        @(negedge clk);
        ImemRspValid = 1'b0;
        ImemRspData  = '0;
        if (q.size() > 0 && q[0].due == cyc_n) begin
            ImemRspValid = 1'b1;
            ImemRspData  = mem_data(q[0].addr);
            q.delete(0);
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        PcSel = 1'b0; NextPC = '0; Stall = 1'b0;
        ImemRspValid = 1'b0; ImemRspData = '0;
        q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc_n = 0; n_fire = 0; exp_pc = '0;
        #1;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 20 && !InstrValid; i++) cyc();
        check(tag, 32'(InstrValid), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset values
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_req_valid", 32'(ImemReqValid), 32'd0);
        check("rst_req_addr", 32'(ImemReqAddr), 32'h000);
        check("rst_instr_valid", 32'(InstrValid), 32'd0);
        check("rst_instr", Instr, 32'd0);
        check("rst_instr_pc", 32'(InstrPC), 32'd0);
        check("rst_misaligned", 32'(Misaligned), 32'd0);

        // Sequential fetch with 1-cycle memory
        InstrReady = 1'b1; lat = 1;
        do_reset();
        check("t1_boot_no_req", 32'(ImemReqValid), 32'd0);
        cyc();
        check("t1_c1_valid", 32'(ImemReqValid), 32'd1);
        check("t1_c1_addr", 32'(ImemReqAddr), 32'h000);
        cyc();
        check("t1_c2_addr", 32'(ImemReqAddr), 32'h004);
        check("t1_c2_no_instr", 32'(InstrValid), 32'd0);
        cyc();
        check("t1_c3_instr_valid", 32'(InstrValid), 32'd1);
        check("t1_c3_instr_pc", 32'(InstrPC), 32'h000);
        repeat (12) cyc();

        // Decode blocked: only FIFO_DEPTH requests issued
        InstrReady = 1'b0;
        do_reset();
        repeat (10) cyc();
        check("t2_fire_count", 32'(n_fire), 32'd2);
        check("t2_req_blocked", 32'(ImemReqValid), 32'd0);
        check("t2_head_valid", 32'(InstrValid), 32'd1);
        check("t2_head_pc", 32'(InstrPC), 32'h000);
        InstrReady = 1'b1;
        repeat (10) cyc();
        check("t2_resume", 32'(n_fire > 2), 32'd1);

        // Redirect with two requests outstanding (3-cycle memory)
        lat = 3;
        do_reset();
        repeat (3) cyc();
        check("t3_credit_full", 32'(ImemReqValid), 32'd0);
        PcSel = 1'b1; NextPC = 32'h040;
        cyc();
        PcSel = 1'b0;
        #1;
        check("t3_flushed", 32'(InstrValid), 32'd0);
        check("t3_pc_target", 32'(ImemReqAddr), 32'h040);
        wait_valid("t3_wait");
        check("t3_first_pc", 32'(InstrPC), 32'h040);
        check("t3_first_instr", Instr, mem_data(9'h040));

        // Redirect with response in the same cycle under Stall
        lat = 1;
        do_reset();
        repeat (2) cyc();
        PcSel = 1'b1; NextPC = 32'h080; Stall = 1'b1;
        #1;
        check("t4_no_req_redirect", 32'(ImemReqValid), 32'd0);
        cyc();
        PcSel = 1'b0; Stall = 1'b0;
        #1;
        check("t4_rsp_dropped", 32'(InstrValid), 32'd0);
        check("t4_req_valid", 32'(ImemReqValid), 32'd1);
        check("t4_req_addr", 32'(ImemReqAddr), 32'h080);
        wait_valid("t4_wait");
        check("t4_first_pc", 32'(InstrPC), 32'h080);

        // Misaligned redirect target
        PcSel = 1'b1; NextPC = 32'h046;
        #1;
        check("t5_mis_same_cycle", 32'(Misaligned), 32'd0);
        cyc();
        PcSel = 1'b0;
        #1;
        check("t5_mis_pulse", 32'(Misaligned), 32'd1);
        check("t5_aligned_pc", 32'(ImemReqAddr), 32'h044);
        check("t5_flushed", 32'(InstrValid), 32'd0);
        cyc();
        check("t5_mis_cleared", 32'(Misaligned), 32'd0);
        wait_valid("t5_wait");
        check("t5_first_pc", 32'(InstrPC), 32'h044);

        // PC wrap from 0x1FC to 0x000
        PcSel = 1'b1; NextPC = 32'h1FC;
        cyc();
        PcSel = 1'b0;
        begin
            int base;
            base = n_fire;
            for (int i = 0; i < 20 && (n_fire - base) < 2; i++) cyc();
            check("t6_fires", 32'((n_fire - base) >= 2), 32'd1);
        end
        check("t6_addr_top", 32'(prev_addr), 32'h1FC);
        check("t6_addr_wrap", 32'(last_addr), 32'h000);
        wait_valid("t6_wait_top");
        check("t6_instr_top", 32'(InstrPC), 32'h1FC);
        cyc();
        wait_valid("t6_wait_wrap");
        check("t6_instr_wrap", 32'(InstrPC), 32'h000);

        // Reset asserted during FLUSH
        lat = 3;
        do_reset();
        repeat (3) cyc();
        PcSel = 1'b1; NextPC = 32'h042;
        cyc();
        PcSel = 1'b0;
        #1;
        check("t7_mis_before", 32'(Misaligned), 32'd1);
        check("t7_pc_before", 32'(ImemReqAddr), 32'h040);
        reset = 1'b1;
        ImemRspValid = 1'b0; ImemRspData = '0;
        q.delete();
        #1;
        check("t7_req_valid", 32'(ImemReqValid), 32'd0);
        check("t7_req_addr", 32'(ImemReqAddr), 32'h000);
        check("t7_instr_valid", 32'(InstrValid), 32'd0);
        check("t7_instr", Instr, 32'd0);
        check("t7_instr_pc", 32'(InstrPC), 32'd0);
        check("t7_misaligned", 32'(Misaligned), 32'd0);
        lat = 1;
        do_reset();
        repeat (3) cyc();
        check("t7_restart_valid", 32'(InstrValid), 32'd1);
        check("t7_restart_pc", 32'(InstrPC), 32'h000);
        repeat (4) cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
